// File: rtl/issue_wakeup_queue.sv
// issue_wakeup_queue
//   Collapsing, age-ordered issue queue between dispatch and EXE. Slot 0 is
//   the oldest entry; valid entries always occupy slots 0..count-1. Entries
//   wait until both source tags are ready (woken by the EXE broadcast bus),
//   and the oldest ready entry is offered to EXE each cycle. A flush from EXE
//   empties the queue.
//
// Ports
//   CLK, RESET            clock, asynchronous active-low reset
//   disp_*                dispatch request/handshake and entry fields
//   broadcast_flag/_map   EXE result broadcast (destination tag produced)
//   flush                 EXE redirect; clears all entries at the edge
//   issue_*               selected entry and issue handshake (zero when idle)
//   count                 number of occupied entries
module issue_wakeup_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int PAY_W = 96,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_dst_map,
  input  logic [PAY_W-1:0] disp_payload,
  input  logic             broadcast_flag,
  input  logic [TAG_W-1:0] broadcast_map,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [TAG_W-1:0] issue_dst_map,
  output logic [TAG_W-1:0] issue_src1_tag,
  output logic [TAG_W-1:0] issue_src2_tag,
  output logic [PAY_W-1:0] issue_payload,
  output logic [CNT_W-1:0] count
);

  // Stored entries
  logic             vld_q    [DEPTH];
  logic [TAG_W-1:0] s1_tag_q [DEPTH];
  logic             s1_rdy_q [DEPTH];
  logic [TAG_W-1:0] s2_tag_q [DEPTH];
  logic             s2_rdy_q [DEPTH];
  logic [TAG_W-1:0] dst_q    [DEPTH];
  logic [PAY_W-1:0] pay_q    [DEPTH];

  // Entries with this cycle's wakeup applied; one extra empty slot on top so
  // the shift-down view never indexes past the array.
  logic             e_vld    [DEPTH+1];
  logic [TAG_W-1:0] e_s1_tag [DEPTH+1];
  logic             e_s1_rdy [DEPTH+1];
  logic [TAG_W-1:0] e_s2_tag [DEPTH+1];
  logic             e_s2_rdy [DEPTH+1];
  logic [TAG_W-1:0] e_dst    [DEPTH+1];
  logic [PAY_W-1:0] e_pay    [DEPTH+1];

  // Next-state entries
  logic             n_vld    [DEPTH];
  logic [TAG_W-1:0] n_s1_tag [DEPTH];
  logic             n_s1_rdy [DEPTH];
  logic [TAG_W-1:0] n_s2_tag [DEPTH];
  logic             n_s2_rdy [DEPTH];
  logic [TAG_W-1:0] n_dst    [DEPTH];
  logic [PAY_W-1:0] n_pay    [DEPTH];

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             issue_fire;
  logic [CNT_W-1:0] wr_idx;
  logic             ins_s1_rdy;
  logic             ins_s2_rdy;

  // Select: lowest-index (oldest) entry with both sources ready. Uses only
  // registered ready bits, so a broadcast never wakes an entry combinationally.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && s1_rdy_q[i] && s2_rdy_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_valid    = sel_found && !flush;
  assign issue_dst_map  = issue_valid ? dst_q[sel_idx]    : '0;
  assign issue_src1_tag = issue_valid ? s1_tag_q[sel_idx] : '0;
  assign issue_src2_tag = issue_valid ? s2_tag_q[sel_idx] : '0;
  assign issue_payload  = issue_valid ? pay_q[sel_idx]    : '0;

  // Ready is not credited for a same-cycle issue, so it depends only on count.
  assign disp_ready = (count < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign issue_fire = issue_valid && issue_ready;

  // When an issue fires the survivors collapse by one, so the free slot
  // moves down with them.
  assign wr_idx = count - CNT_W'(issue_fire);

  // Tag 0 is hard-wired ready; a same-cycle broadcast also counts at insert.
  assign ins_s1_rdy = disp_src1_rdy || (disp_src1_tag == '0) ||
                      (broadcast_flag && (disp_src1_tag == broadcast_map));
  assign ins_s2_rdy = disp_src2_rdy || (disp_src2_tag == '0) ||
                      (broadcast_flag && (disp_src2_tag == broadcast_map));

  // Wakeup view of every slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      e_vld[i]    = vld_q[i];
      e_s1_tag[i] = s1_tag_q[i];
      e_s1_rdy[i] = s1_rdy_q[i] || (broadcast_flag && (s1_tag_q[i] == broadcast_map));
      e_s2_tag[i] = s2_tag_q[i];
      e_s2_rdy[i] = s2_rdy_q[i] || (broadcast_flag && (s2_tag_q[i] == broadcast_map));
      e_dst[i]    = dst_q[i];
      e_pay[i]    = pay_q[i];
    end
    e_vld[DEPTH]    = 1'b0;
    e_s1_tag[DEPTH] = '0;
    e_s1_rdy[DEPTH] = 1'b0;
    e_s2_tag[DEPTH] = '0;
    e_s2_rdy[DEPTH] = 1'b0;
    e_dst[DEPTH]    = '0;
    e_pay[DEPTH]    = '0;
  end

  // Collapse above the issued slot, then drop the dispatched entry in place
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
        n_vld[i]    = e_vld[i+1];
        n_s1_tag[i] = e_s1_tag[i+1];
        n_s1_rdy[i] = e_s1_rdy[i+1];
        n_s2_tag[i] = e_s2_tag[i+1];
        n_s2_rdy[i] = e_s2_rdy[i+1];
        n_dst[i]    = e_dst[i+1];
        n_pay[i]    = e_pay[i+1];
      end else begin
        n_vld[i]    = e_vld[i];
        n_s1_tag[i] = e_s1_tag[i];
        n_s1_rdy[i] = e_s1_rdy[i];
        n_s2_tag[i] = e_s2_tag[i];
        n_s2_rdy[i] = e_s2_rdy[i];
        n_dst[i]    = e_dst[i];
        n_pay[i]    = e_pay[i];
      end
      if (disp_fire && (CNT_W'(i) == wr_idx)) begin
        n_vld[i]    = 1'b1;
        n_s1_tag[i] = disp_src1_tag;
        n_s1_rdy[i] = ins_s1_rdy;
        n_s2_tag[i] = disp_src2_tag;
        n_s2_rdy[i] = ins_s2_rdy;
        n_dst[i]    = disp_dst_map;
        n_pay[i]    = disp_payload;
      end
    end
  end

  // Control state: valid bits and occupancy; flush wins over everything
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
      count <= '0;
    end else begin
      vld_q <= n_vld;
      count <= count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

  // Entry contents carry no reset; they are qualified by the valid bits
  always_ff @(posedge CLK) begin
    s1_tag_q <= n_s1_tag;
    s1_rdy_q <= n_s1_rdy;
    s2_tag_q <= n_s2_tag;
    s2_rdy_q <= n_s2_rdy;
    dst_q    <= n_dst;
    pay_q    <= n_pay;
  end

endmodule

// File: tb/tb_issue_wakeup_queue.sv
// Directed bench for issue_wakeup_queue with hand-computed expected values.
module tb_issue_wakeup_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PAY_W = 96;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             disp_valid;
  logic             disp_ready;
  logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag;
  logic             disp_src1_rdy, disp_src2_rdy;
  logic [TAG_W-1:0] disp_dst_map;
  logic [PAY_W-1:0] disp_payload;
  logic             broadcast_flag;
  logic [TAG_W-1:0] broadcast_map;
  logic             flush;
  logic             issue_valid;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_dst_map, issue_src1_tag, issue_src2_tag;
  logic [PAY_W-1:0] issue_payload;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  issue_wakeup_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAY_W(PAY_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_map(disp_dst_map), .disp_payload(disp_payload),
    .broadcast_flag(broadcast_flag), .broadcast_map(broadcast_map),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dst_map(issue_dst_map), .issue_src1_tag(issue_src1_tag),
    .issue_src2_tag(issue_src2_tag), .issue_payload(issue_payload),
    .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1 time unit after it.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic v, input logic [TAG_W-1:0] t1, input logic r1,
                      input logic [TAG_W-1:0] t2, input logic r2,
                      input logic [TAG_W-1:0] dst);
    disp_valid    = v;
    disp_src1_tag = t1;
    disp_src1_rdy = r1;
    disp_src2_tag = t2;
    disp_src2_rdy = r2;
    disp_dst_map  = dst;
    disp_payload  = {32'hA5A5_0000, 58'd0, dst};
  endtask

  task automatic bcast(input logic f, input logic [TAG_W-1:0] m);
    broadcast_flag = f;
    broadcast_map  = m;
  endtask

  initial begin
    RESET = 1'b0;
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bcast(1'b0, '0);
    flush       = 1'b0;
    issue_ready = 1'b0;
    #3;
    check("rst_count", count, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_dst", issue_dst_map, 0);
    check("rst_issue_pay", issue_payload, 0);
    #14 RESET = 1'b1;
    cyc();

    // Three ready entries stream through back-to-back
    issue_ready = 1'b1;
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5);
    cyc();
    check("t1_c1_valid", issue_valid, 1);
    check("t1_c1_dst", issue_dst_map, 5);
    check("t1_c1_pay", issue_payload, {32'hA5A5_0000, 58'd0, 6'd5});
    check("t1_c1_src1", issue_src1_tag, 1);
    check("t1_c1_count", count, 1);
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd6);
    cyc();
    check("t1_c2_dst", issue_dst_map, 6);
    check("t1_c2_count", count, 1);
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd7);
    cyc();
    check("t1_c3_dst", issue_dst_map, 7);
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    cyc();
    check("t1_end_count", count, 0);
    check("t1_end_valid", issue_valid, 0);

    // Younger ready entry bypasses an older waiting one; wakeup by broadcast
    issue_ready = 1'b0;
    disp(1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'd10);
    cyc();
    check("t2_a_wait", issue_valid, 0);
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bcast(1'b1, 6'd33);
    cyc();
    check("t2_foreign_bcast", issue_valid, 0);
    bcast(1'b0, '0);
    disp(1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd11);
    cyc();
    check("t2_b_first", issue_dst_map, 11);
    check("t2_count2", count, 2);
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    issue_ready = 1'b1;
    bcast(1'b1, 6'd9);
    #1;
    check("t2_no_comb_wake", issue_dst_map, 11);
    cyc();
    bcast(1'b0, '0);
    check("t2_a_woken", issue_valid, 1);
    check("t2_a_dst", issue_dst_map, 10);
    check("t2_a_src1", issue_src1_tag, 9);
    check("t2_count1", count, 1);
    cyc();
    check("t2_drained", count, 0);

    // Dispatch and matching broadcast in the same cycle
    issue_ready = 1'b0;
    disp(1'b1, 6'd0, 1'b0, 6'd12, 1'b0, 6'd20);
    bcast(1'b1, 6'd12);
    cyc();
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bcast(1'b0, '0);
    check("t3_valid", issue_valid, 1);
    check("t3_dst", issue_dst_map, 20);
    issue_ready = 1'b1;
    cyc();
    check("t3_drained", count, 0);

    // Fill to DEPTH with nothing ready
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(1'b1, 6'(40 + i), 1'b0, 6'd0, 1'b0, 6'(50 + i));
      cyc();
    end
    check("t4_full_count", count, 8);
    check("t4_full_ready", disp_ready, 0);
    check("t4_full_valid", issue_valid, 0);
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd63);
    cyc();
    check("t4_drop_count", count, 8);
    check("t4_drop_valid", issue_valid, 0);
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bcast(1'b1, 6'd43);
    cyc();
    check("t4_slot3_dst", issue_dst_map, 53);
    bcast(1'b0, '0);
    issue_ready = 1'b1;
    cyc();
    check("t4_after_count", count, 7);
    check("t4_after_ready", disp_ready, 1);
    check("t4_after_valid", issue_valid, 0);
    issue_ready = 1'b0;
    bcast(1'b1, 6'd47);
    cyc();
    check("t4_shift_dst", issue_dst_map, 57);
    bcast(1'b1, 6'd44);
    cyc();
    check("t4_older_takes", issue_dst_map, 54);
    bcast(1'b0, '0);
    issue_ready = 1'b1;
    cyc();
    check("t4_next_dst", issue_dst_map, 57);
    check("t4_count6", count, 6);
    cyc();
    check("t4_count5", count, 5);
    check("t4_none_ready", issue_valid, 0);

    // Flush together with dispatch, issue and broadcast
    issue_ready = 1'b0;
    bcast(1'b1, 6'd40);
    cyc();
    check("t6_pre_dst", issue_dst_map, 50);
    flush       = 1'b1;
    issue_ready = 1'b1;
    bcast(1'b1, 6'd41);
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30);
    #1;
    check("t6_flush_mask", issue_valid, 0);
    check("t6_flush_zero", issue_dst_map, 0);
    cyc();
    flush = 1'b0;
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bcast(1'b0, '0);
    check("t6_count", count, 0);
    check("t6_valid", issue_valid, 0);
    cyc();
    check("t6_no_insert", count, 0);

    // Ready entries held while EXE stalls
    issue_ready = 1'b0;
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30);
    cyc();
    disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd31);
    cyc();
    disp(1'b0, '0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_dst", issue_dst_map, 30);
      check("t5_hold_count", count, 2);
      cyc();
    end
    issue_ready = 1'b1;
    cyc();
    issue_ready = 1'b0;
    check("t5_one_removed", count, 1);
    check("t5_next_dst", issue_dst_map, 31);
    cyc();
    check("t5_still_one", count, 1);

    // Asynchronous reset mid-operation
    #2 RESET = 1'b0;
    #1;
    check("t7_rst_count", count, 0);
    check("t7_rst_valid", issue_valid, 0);
    check("t7_rst_dst", issue_dst_map, 0);
    check("t7_rst_ready", disp_ready, 1);
    #3 RESET = 1'b1;
    cyc();
    check("t7_after_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
